// File: rtl/mips_pkg.sv
// Shared core constants and types: architectural word width, register index width,
// register count and the hardwired-zero register number.
package mips_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;
   localparam int NREGS     = 2 ** REG_IDX_W;
   localparam int REG_ZERO  = 0;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]      word_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending-write bit per architectural register, set by ID issue,
// cleared by WB writeback, with two combinational lookups for the read ports.
module reg_scoreboard
   import mips_pkg::*;
#(
   parameter int IDX_W = REG_IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_e,
   input  logic [IDX_W-1:0] issue_idx,
   input  logic             reg_we,
   input  logic [IDX_W-1:0] wb_idx,
   input  logic [IDX_W-1:0] ra_idx,
   input  logic [IDX_W-1:0] rb_idx,
   output logic             ra_busy,
   output logic             rb_busy
);

   localparam int DEPTH = 2 ** IDX_W;

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;

   // Clear is applied before set so a same-edge issue to the written index leaves it busy.
   always_comb begin
      // NOTE: default assignment first keeps this block free of inferred latches.
      busy_nxt = busy;
      if (reg_we) begin
         busy_nxt[wb_idx] = 1'b0;
      end
      if (issue_e) begin
         busy_nxt[issue_idx] = 1'b1;
      end
      busy_nxt[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   assign ra_busy = busy[ra_idx];
   assign rb_busy = busy[rb_idx];

endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file with busy-bit scoreboard; two combinational read ports.
// Optional same-cycle writeback bypass enabled by defining REGFILE_BYPASS_EN.
module reg_file_sb
   import mips_pkg::*;
#(
   parameter int DATA_W = XLEN,
   parameter int IDX_W  = REG_IDX_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_we,
   input  logic [IDX_W-1:0]  wb_idx,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [IDX_W-1:0]  ra_idx,
   input  logic [IDX_W-1:0]  rb_idx,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   output logic              ra_busy,
   output logic              rb_busy,
   input  logic              issue_e,
   input  logic [IDX_W-1:0]  issue_idx,
   output logic              stall
);

   localparam int               DEPTH = 2 ** IDX_W;
   localparam logic [IDX_W-1:0] ZERO  = IDX_W'(REG_ZERO);

   logic [DATA_W-1:0] regs [DEPTH];
   logic              ra_busy_raw;
   logic              rb_busy_raw;
   logic              wb_valid;

   assign wb_valid = reg_we && (wb_idx != ZERO);

   always_ff @(posedge clk) begin
      // NOTE: the array is flop-based and must read zero after reset, so every entry is reset.
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_valid) begin
         regs[wb_idx] <= wb_data;
      end
   end

   reg_scoreboard #(.IDX_W(IDX_W)) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .issue_e   (issue_e),
      .issue_idx (issue_idx),
      .reg_we    (reg_we),
      .wb_idx    (wb_idx),
      .ra_idx    (ra_idx),
      .rb_idx    (rb_idx),
      .ra_busy   (ra_busy_raw),
      .rb_busy   (rb_busy_raw)
   );

   always_comb begin
      ra_data = (ra_idx == ZERO) ? '0 : regs[ra_idx];
      rb_data = (rb_idx == ZERO) ? '0 : regs[rb_idx];
      ra_busy = ra_busy_raw;
      rb_busy = rb_busy_raw;
`ifdef REGFILE_BYPASS_EN
      // A writeback landing this cycle both supplies the data and resolves the hazard.
      if (wb_valid && (wb_idx == ra_idx)) begin
         ra_data = wb_data;
         ra_busy = 1'b0;
      end
      if (wb_valid && (wb_idx == rb_idx)) begin
         rb_data = wb_data;
         rb_busy = 1'b0;
      end
`endif
   end

   assign stall = ra_busy | rb_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic
// against an array-based reference model; honours REGFILE_BYPASS_EN.
module tb_reg_file_sb;

   localparam int DW = 32;
   localparam int IW = 5;
   localparam int N  = 32;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          reg_we;
   logic [IW-1:0] wb_idx;
   logic [DW-1:0] wb_data;
   logic [IW-1:0] ra_idx;
   logic [IW-1:0] rb_idx;
   logic [DW-1:0] ra_data;
   logic [DW-1:0] rb_data;
   logic          ra_busy;
   logic          rb_busy;
   logic          issue_e;
   logic [IW-1:0] issue_idx;
   logic          stall;

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0] m_regs [N];
   bit            m_busy [N];

   always #5 clk = ~clk;

   reg_file_sb dut (
      .clk       (clk),
      .rst       (rst),
      .reg_we    (reg_we),
      .wb_idx    (wb_idx),
      .wb_data   (wb_data),
      .ra_idx    (ra_idx),
      .rb_idx    (rb_idx),
      .ra_data   (ra_data),
      .rb_data   (rb_data),
      .ra_busy   (ra_busy),
      .rb_busy   (rb_busy),
      .issue_e   (issue_e),
      .issue_idx (issue_idx),
      .stall     (stall)
   );

   // Reference model: what a read of idx should return this cycle.
   function automatic logic [DW-1:0] exp_data(input int idx);
      if (idx == 0) return '0;
      if (BYPASS && reg_we && int'(wb_idx) == idx) return wb_data;
      return m_regs[idx];
   endfunction

   function automatic bit exp_busy(input int idx);
      if (idx == 0) return 1'b0;
      if (BYPASS && reg_we && int'(wb_idx) == idx) return 1'b0;
      return m_busy[idx];
   endfunction

   // Advance one clock, updating the model from the inputs sampled at the edge.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (reg_we && wb_idx != 0) begin
            m_regs[wb_idx] = wb_data;
            m_busy[wb_idx] = 1'b0;
         end
         if (issue_e && issue_idx != 0) m_busy[issue_idx] = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; reg_we = 1'b0; wb_idx = '0; wb_data = '0;
      issue_e = 1'b0; issue_idx = '0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 1; i < N; i++) begin
         ra_idx = IW'(i);
         rb_idx = IW'(N - i);
         #1;
         vectors++;
         if (ra_data !== '0 || rb_data !== '0) begin
            miscompares++;
            $display("FAIL reset_data idx=%0d: got a=%h b=%h expected 0", i, ra_data, rb_data);
         end
         vectors++;
         if (ra_busy !== 1'b0 || rb_busy !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy idx=%0d: got %b%b%b expected 000", i, ra_busy, rb_busy, stall);
         end
      end
      reg_we = 1'b1; wb_idx = '0; wb_data = 32'hDEAD_BEEF; ra_idx = '0;
      #1;
      vectors++;
      if (ra_data !== '0) begin
         miscompares++;
         $display("FAIL zero_write_same: got %h expected 0", ra_data);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (ra_data !== '0) begin
         miscompares++;
         $display("FAIL zero_write_after: got %h expected 0", ra_data);
      end
   endtask

   task automatic test_write_read();
      logic [DW-1:0] exp;
      ra_idx = 5'd5;
      reg_we = 1'b1; wb_idx = 5'd5; wb_data = 32'h1234_5678;
      #1;
      exp = BYPASS ? 32'h1234_5678 : 32'h0;
      vectors++;
      if (ra_data !== exp) begin
         miscompares++;
         $display("FAIL write_same_cycle: got %h expected %h", ra_data, exp);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (ra_data !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL write_next_cycle: got %h expected 12345678", ra_data);
      end
   endtask

   task automatic test_scoreboard();
      ra_idx = 5'd7; rb_idx = 5'd0;
      issue_e = 1'b1; issue_idx = 5'd7;
      #1;
      vectors++;
      if (ra_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_before_edge: got %b expected 0", ra_busy);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (ra_busy !== 1'b1 || stall !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_after_issue: got busy=%b stall=%b expected 1 1", ra_busy, stall);
      end
      reg_we = 1'b1; wb_idx = 5'd7; wb_data = 32'd42;
      #1;
      vectors++;
      if (ra_busy !== !BYPASS || stall !== !BYPASS || ra_data !== (BYPASS ? 32'd42 : 32'd0)) begin
         miscompares++;
         $display("FAIL wb_cycle: got busy=%b stall=%b data=%h expected %b %b %h",
                  ra_busy, stall, ra_data, !BYPASS, !BYPASS, BYPASS ? 32'd42 : 32'd0);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (ra_busy !== 1'b0 || stall !== 1'b0 || ra_data !== 32'd42) begin
         miscompares++;
         $display("FAIL after_wb: got busy=%b stall=%b data=%h expected 0 0 0000002a",
                  ra_busy, stall, ra_data);
      end
   endtask

   task automatic test_simul_set_clear();
      issue_e = 1'b1; issue_idx = 5'd9;
      tick();
      reg_we = 1'b1; wb_idx = 5'd9; wb_data = 32'h55;
      tick();
      idle();
      ra_idx = 5'd9;
      #1;
      vectors++;
      if (ra_busy !== 1'b1 || ra_data !== 32'h55) begin
         miscompares++;
         $display("FAIL set_wins: got busy=%b data=%h expected 1 00000055", ra_busy, ra_data);
      end
      reg_we = 1'b1; wb_idx = 5'd9; wb_data = 32'h66;
      tick();
      idle();
      #1;
      vectors++;
      if (ra_busy !== 1'b0 || ra_data !== 32'h66) begin
         miscompares++;
         $display("FAIL second_wb: got busy=%b data=%h expected 0 00000066", ra_busy, ra_data);
      end
   endtask

   task automatic test_dual_port();
      issue_e = 1'b1; issue_idx = 5'd3;
      tick();
      idle();
      ra_idx = 5'd3; rb_idx = 5'd3;
      #1;
      vectors++;
      if (ra_busy !== 1'b1 || rb_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL dual_same: got %b %b expected 1 1", ra_busy, rb_busy);
      end
      rb_idx = 5'd4;
      #1;
      vectors++;
      if (ra_busy !== 1'b1 || rb_busy !== 1'b0 || stall !== 1'b1) begin
         miscompares++;
         $display("FAIL dual_a_only: got %b %b stall=%b expected 1 0 1", ra_busy, rb_busy, stall);
      end
      reg_we = 1'b1; wb_idx = 5'd3; wb_data = 32'h3;
      tick();
      idle();
   endtask

   task automatic test_reset_mid();
      reg_we = 1'b1; wb_idx = 5'd12; wb_data = 32'd7;
      issue_e = 1'b1; issue_idx = 5'd12;
      tick();
      idle();
      ra_idx = 5'd12;
      #1;
      vectors++;
      if (ra_busy !== 1'b1 || ra_data !== 32'd7) begin
         miscompares++;
         $display("FAIL pre_reset: got busy=%b data=%h expected 1 00000007", ra_busy, ra_data);
      end
      rst = 1'b1; reg_we = 1'b1; wb_idx = 5'd12; wb_data = 32'd9;
      issue_e = 1'b1; issue_idx = 5'd13;
      tick();
      idle();
      rb_idx = 5'd13;
      #1;
      vectors++;
      if (ra_busy !== 1'b0 || ra_data !== '0 || rb_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: got busy=%b data=%h b_busy=%b expected 0 0 0",
                  ra_busy, ra_data, rb_busy);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst       = ($urandom_range(0, 49) == 0);
         reg_we    = $urandom_range(0, 1);
         wb_idx    = IW'($urandom);
         wb_data   = $urandom;
         issue_e   = $urandom_range(0, 1);
         issue_idx = IW'($urandom);
         ra_idx    = ($urandom_range(0, 3) == 0) ? wb_idx : IW'($urandom);
         rb_idx    = IW'($urandom);
         #1;
         vectors++;
         if (ra_data !== exp_data(ra_idx) || rb_data !== exp_data(rb_idx)) begin
            miscompares++;
            $display("FAIL rand_data n=%0d: got a=%h b=%h expected a=%h b=%h",
                     n, ra_data, rb_data, exp_data(ra_idx), exp_data(rb_idx));
         end
         vectors++;
         if (ra_busy !== exp_busy(ra_idx) || rb_busy !== exp_busy(rb_idx) ||
             stall !== (exp_busy(ra_idx) | exp_busy(rb_idx))) begin
            miscompares++;
            $display("FAIL rand_busy n=%0d: got %b%b%b expected %b%b%b", n, ra_busy, rb_busy,
                     stall, exp_busy(ra_idx), exp_busy(rb_idx),
                     exp_busy(ra_idx) | exp_busy(rb_idx));
         end
         tick();
      end
      idle();
   endtask

   initial begin
      ra_idx = '0;
      rb_idx = '0;
      test_reset();
      test_write_read();
      test_scoreboard();
      test_simul_set_clear();
      test_dual_port();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
